// File: rtl/fft_sequencer.sv
// Address and control sequencer for a 64-point in-place radix-2 FFT: loads samples in
// bit-reversed order, issues six stages of butterflies, then reads the bins out in natural order.
module fft_sequencer #(
    parameter int BF_WB_MAX = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_we,
    output logic [5:0] load_addr,
    output logic       bf_valid,
    output logic [5:0] bf_addr_a,
    output logic [5:0] bf_addr_b,
    output logic [4:0] tw_idx,
    output logic [2:0] bf_stage,
    input  logic       wb_valid,
    input  logic       out_ready,
    output logic       rd_en,
    output logic [5:0] rd_addr,
    output logic       rd_last,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(BF_WB_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_UNLOAD  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    smp_cnt_q, smp_cnt_d;
    logic [4:0]    k_q, k_d;
    logic [2:0]    stage_q, stage_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [5:0]    rd_cnt_q, rd_cnt_d;
    logic          done_q, done_d;

    // Handshakes: a sample moves when in_valid & in_ready; a bin is read when out_ready is
    // high in UNLOAD; each butterfly is issued by a one-cycle bf_valid and retired by one wb_valid.
    logic accept, issue, wb_ok, rd_fire;
    assign accept  = in_valid && (state_q == S_IDLE || state_q == S_LOAD);
    assign issue   = (state_q == S_COMPUTE) && (out_cnt_q != CW'(BF_WB_MAX));
    assign wb_ok   = wb_valid && (state_q == S_COMPUTE || state_q == S_DRAIN);
    assign rd_fire = (state_q == S_UNLOAD) && out_ready;

    function automatic logic [5:0] bit_rev6(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    logic [5:0] k_ext, half, j_idx, addr_a;
    always_comb begin
        k_ext  = {1'b0, k_q};
        half   = 6'd1 << stage_q;
        j_idx  = k_ext & (half - 6'd1);
        addr_a = ((k_ext >> stage_q) << (stage_q + 3'd1)) | j_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            smp_cnt_q <= '0;
            k_q       <= '0;
            stage_q   <= '0;
            out_cnt_q <= '0;
            rd_cnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            out_cnt_q <= out_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        k_d       = k_q;
        stage_d   = stage_q;
        rd_cnt_d  = rd_cnt_q;
        done_d    = 1'b0;
        out_cnt_d = out_cnt_q;
        // Simultaneous issue and writeback cancel; a stray writeback never drives the count negative.
        if (issue && !wb_ok) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!issue && wb_ok && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                k_d      = '0;
                stage_d  = '0;
                rd_cnt_d = '0;
                if (accept) begin
                    smp_cnt_d = 6'd1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    smp_cnt_d = smp_cnt_q + 6'd1;
                    if (smp_cnt_q == 6'd63) state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (issue) begin
                    k_d = k_q + 5'd1;
                    if (k_q == 5'd31) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Next stage reads this stage's results, so wait for every writeback.
                if (out_cnt_d == '0) begin
                    if (stage_q == 3'd5) begin
                        state_d = S_UNLOAD;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_UNLOAD: begin
                if (rd_fire) begin
                    rd_cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_q == 6'd63) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
        load_we   = accept;
        load_addr = '0;
        if (accept && state_q == S_LOAD) load_addr = bit_rev6(smp_cnt_q);
        bf_valid  = issue;
        bf_addr_a = issue ? addr_a : 6'd0;
        bf_addr_b = issue ? addr_a + half : 6'd0;
        tw_idx    = issue ? 5'(j_idx << (3'd5 - stage_q)) : 5'd0;
        bf_stage  = (state_q == S_COMPUTE || state_q == S_DRAIN) ? stage_q : 3'd0;
        rd_en     = rd_fire;
        rd_addr   = rd_fire ? rd_cnt_q : 6'd0;
        rd_last   = rd_fire && (rd_cnt_q == 6'd63);
        busy      = (state_q != S_IDLE);
        done      = done_q && (state_q == S_IDLE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: one instance with a 3-cycle writeback model, a second
// (BF_WB_MAX=2) whose writebacks are withheld to exercise the issue stall.
module tb_fft_sequencer;

    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;

    logic clk = 1'b0;
    logic rst, in_valid, wb_valid, out_ready, wb_valid_b;

    logic       in_ready, load_we, bf_valid, rd_en, rd_last, busy, done;
    logic [5:0] load_addr, bf_addr_a, bf_addr_b, rd_addr;
    logic [4:0] tw_idx;
    logic [2:0] bf_stage, dbg_state;

    logic       in_ready_b, load_we_b, bf_valid_b, rd_en_b, rd_last_b, busy_b, done_b;
    logic [5:0] load_addr_b, bf_addr_a_b, bf_addr_b_b, rd_addr_b;
    logic [4:0] tw_idx_b;
    logic [2:0] bf_stage_b, dbg_state_b;

    int n_tests = 0;
    int n_fail = 0;
    int compute_cycles = 0;
    int done_cnt = 0;
    int bf_cnt_b = 0;
    logic [2:0] wb_hist = '0;

    logic [5:0]  exp_load_q[$];
    logic [19:0] exp_bf_q[$];
    logic [6:0]  exp_rd_q[$];

    always #5 clk = ~clk;

    fft_sequencer #(.BF_WB_MAX(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load_we(load_we),
        .load_addr(load_addr), .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
        .tw_idx(tw_idx), .bf_stage(bf_stage), .wb_valid(wb_valid), .out_ready(out_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_last(rd_last), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    fft_sequencer #(.BF_WB_MAX(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .load_we(load_we_b),
        .load_addr(load_addr_b), .bf_valid(bf_valid_b), .bf_addr_a(bf_addr_a_b),
        .bf_addr_b(bf_addr_b_b), .tw_idx(tw_idx_b), .bf_stage(bf_stage_b), .wb_valid(wb_valid_b),
        .out_ready(out_ready), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_last(rd_last_b),
        .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] rev6(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_outs"}, 32'({load_we, load_addr, bf_valid, bf_addr_a, bf_addr_b, tw_idx,
                                   bf_stage, rd_en, rd_addr, rd_last, busy, done}), 32'd0);
    endtask

    // Writeback model: every issue of the main instance returns exactly 3 cycles later.
    always begin
        @(posedge clk);
        #1;
        wb_valid = wb_hist[2];
        wb_hist  = {wb_hist[1:0], bf_valid};
    end

    // Scoreboard side: pop expectations as the DUT produces strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_we) begin
                if (exp_load_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
                else check("load_addr", 32'(load_addr), 32'(exp_load_q.pop_front()));
            end
            if (bf_valid) begin
                if (exp_bf_q.size() == 0) check("bf_unexpected", 32'd1, 32'd0);
                else check("bf_issue", 32'({bf_stage, tw_idx, bf_addr_a, bf_addr_b}),
                           32'(exp_bf_q.pop_front()));
            end else if (dbg_state == ST_COMPUTE || dbg_state == ST_DRAIN) begin
                check("bf_addr_idle", 32'({bf_addr_a, bf_addr_b, tw_idx}), 32'd0);
            end
            if (rd_en) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_addr_last", 32'({rd_last, rd_addr}), 32'(exp_rd_q.pop_front()));
            end else if (dbg_state == ST_UNLOAD) begin
                check("rd_addr_idle", 32'({rd_last, rd_addr}), 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            if (dbg_state == ST_COMPUTE || dbg_state == ST_DRAIN) compute_cycles++;
            if (bf_valid_b) bf_cnt_b++;
        end
    end

    task automatic load_frame(input bit gaps);
        int half, j, a;
        compute_cycles = 0;
        for (int s = 0; s < 6; s++) begin
            half = 1 << s;
            for (int k = 0; k < 32; k++) begin
                j = k % half;
                a = (k / half) * 2 * half + j;
                exp_bf_q.push_back({3'(s), 5'(j * (32 / half)), 6'(a), 6'(a + half)});
            end
        end
        for (int n = 0; n < 64; n++) exp_rd_q.push_back({(n == 63), 6'(n)});
        for (int n = 0; n < 64; n++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            exp_load_q.push_back(rev6(6'(n)));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_fall", 32'(in_ready), 32'd0);
    endtask

    task automatic finish_frame(input bit toggle);
        int done0;
        for (int c = 0; c < 600 && dbg_state != ST_UNLOAD; c++) begin
            @(posedge clk);
            #1;
        end
        check("reach_unload", 32'(dbg_state), 32'(ST_UNLOAD));
        check("compute_cycles", 32'(compute_cycles), 32'd210);
        done0 = done_cnt;
        for (int c = 0; c < 400 && done_cnt == done0; c++) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt - done0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("bf_q_empty", 32'(exp_bf_q.size()), 32'd0);
        check("load_q_empty", 32'(exp_load_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        wb_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Frame 1: both instances load; the second stalls with writebacks withheld.
        load_frame(1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_issues", 32'(bf_cnt_b), 32'd2);
        check("stall_bf_valid", 32'(bf_valid_b), 32'd0);
        wb_valid_b = 1'b1;
        @(posedge clk);
        #1;
        wb_valid_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("stall_one_more", 32'(bf_cnt_b), 32'd3);
        finish_frame(1'b1);

        // Frame 2: aborted by reset in the middle of stage 3.
        load_frame(1'b0);
        for (int c = 0; c < 400 && !(bf_valid && bf_stage == 3'd3); c++) begin
            @(posedge clk);
            #1;
        end
        check("reach_stage3", 32'(bf_stage), 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_bf_q.delete();
        exp_rd_q.delete();
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Frame 3: fresh frame with input gaps after the abort.
        load_frame(1'b1);
        finish_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
